pong_round_ctrl: RTL
====================

# pong_round_ctrl

Game-flow controller for the two-player Pong datapath. It sequences each match through idle, serve delay, live rally and game over. It owns both player scores and the BCD match countdown, and gates the ball/paddle engine through `stop` and a one-cycle `serve` launch pulse. It sits between the keypad/start button, the 1 Hz divider and the ball engine (`miss1`/`miss2`), and feeds the score dot-matrix and seven-segment drivers.

## Interface
- `GAME_MIN`, default 3: match length in minutes; legal range 1-9.
- `SERVE_SEC`, default 2: serve delay in 1 Hz ticks; legal range 1-15.
- `WIN_SCORE`, default 7: score that ends the match early; legal range 1-7.
- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: start button, level input; only rising edges are acted on.
- `tick_1hz` in 1: one-`clk`-wide enable pulse, once per second.
- `miss1` in 1: one-cycle pulse; the ball passed paddle 1.
- `miss2` in 1: one-cycle pulse; the ball passed paddle 2.
- `stop` out 1: 1 freezes the ball/paddle engine.
- `serve` out 1: one-cycle pulse telling the engine to re-center and launch the ball.
- `game_over` out 1: high while in OVER.
- `winner` out 2: 01 means P1 wins, 10 means P2 wins, 11 means tie. Valid only while `game_over` is high; 00 otherwise.
- `score1`, `score2` out 3 each: current scores.
- `min` out 4: BCD minutes remaining.
- `sec1` out 4: BCD tens of seconds remaining.
- `sec2` out 4: BCD units of seconds remaining.
- `state` out 2: IDLE=0, SERVE=1, PLAY=2, OVER=3.

## Operation
- Start edge detection:
  - `start_q` holds `start` delayed by one cycle; its reset value is 1.
  - `start_rise` = `start & ~start_q`.
  - A button held through reset release does not start a match.
- IDLE (reset state):
  - `stop`=1.
  - `start_rise` goes to SERVE, clears both scores, loads the timer with `GAME_MIN`:00 and loads `serve_cnt` with `SERVE_SEC`.
- SERVE:
  - `stop`=1; the match timer is frozen.
  - Each `tick_1hz` decrements `serve_cnt`.
  - A tick arriving while `serve_cnt`==1 goes to PLAY.
  - `start`, `miss1` and `miss2` are ignored.
- PLAY:
  - `stop`=0.
  - Countdown on each tick:
    - if `sec2`>0, decrement `sec2`;
    - else if `sec1`>0, decrement `sec1` and set `sec2`=9;
    - else decrement `min` and set `sec1`=5, `sec2`=9.
  - Scoring: `miss1` alone increments `score2`; `miss2` alone increments `score1`. If both arrive in the same cycle, no score changes and the point is replayed.
  - Any miss with no win goes to SERVE and reloads `serve_cnt`; the timer holds.
  - If a score reaches `WIN_SCORE`, go to OVER. Scores never exceed `WIN_SCORE`.
  - If the timer reaches 0:00, go to OVER.
  - Miss and final tick in the same cycle: the score is applied and the timer is updated; the next state is OVER.
- OVER:
  - `stop`=1, `game_over`=1.
  - `winner` is decided by comparing `score1` and `score2` (equal scores give 11).
  - `start_rise` behaves exactly as it does from IDLE.
- `tick_1hz` in any state other than SERVE and PLAY has no effect.

## Timing
- All outputs are registered except `winner`, which is a combinational compare gated by `game_over`.
- Reset values:
  - `state`=IDLE, `stop`=1, `serve`=0, `game_over`=0, `winner`=00.
  - `score1`=`score2`=0.
  - `min`=`GAME_MIN`, `sec1`=0, `sec2`=0.
  - `serve_cnt`=`SERVE_SEC`, `start_q`=1.
- Input event at edge N: the new `state`, scores and timer are visible after edge N.
- `start_rise` is detected in the cycle `start` is first sampled high after being low.
  - Its effects (state change, score clear, timer/`serve_cnt` load) land on the edge where it is detected.
- `serve`:
  - Goes high on the same edge that enters PLAY and stays high for exactly one cycle.
  - Is never asserted outside the first PLAY cycle.
- Serve delay: PLAY is entered on the edge of the `SERVE_SEC`-th tick counted after SERVE entry.
- A tick in the same cycle as a state-entering edge is consumed by the old state only.
- Reset asserted mid-match returns to reset values immediately, with no `serve` glitch.

## Test plan
- Reset then `start` pulse, with `SERVE_SEC`=2: `state` goes 0→1; after 2 ticks `state`=2, `serve` is high for 1 cycle and `stop`=0.
- `GAME_MIN`=1 in PLAY with 60 ticks: timer sequence 1:00, 0:59 … 0:00; on the 60th tick `state`=3; with scores 0:0, `winner`=11.
- Seven `miss2` pulses, each followed by a full serve delay: `score1` steps 1…7; after the 7th, `state`=3, `winner`=01, `score1` stays 7.
- `miss1` and `miss2` in the same cycle in PLAY: scores unchanged, `state`=1, `serve_cnt` reloaded.
- Hold `start` high through reset release: `state` stays 0. Toggle `start` low→high: `state`=1. Ticks in IDLE leave the timer at `GAME_MIN`:00.
- At 0:01 with scores 2:3, apply `miss2` on the same cycle as a tick: `score1`=3, timer 0:00, `state`=3, `winner`=11. Then `rst` low: all outputs return to reset values.

Source files
------------

// File: rtl/pong_round_ctrl.sv
// Pong match sequencer: idle -> serve delay -> rally -> game over.
// Owns both scores, the BCD match countdown and the engine stop/serve controls.
module pong_round_ctrl #(
   parameter int GAME_MIN  = 3,
   parameter int SERVE_SEC = 2,
   parameter int WIN_SCORE = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       tick_1hz,
   input  logic       miss1,
   input  logic       miss2,
   output logic       stop,
   output logic       serve,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [2:0] score1,
   output logic [2:0] score2,
   output logic [3:0] min,
   output logic [3:0] sec1,
   output logic [3:0] sec2,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      PLAY  = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam logic [3:0] GAME_MIN_L  = 4'(GAME_MIN);
   localparam logic [3:0] SERVE_SEC_L = 4'(SERVE_SEC);
   localparam logic [2:0] WIN_SCORE_L = 3'(WIN_SCORE);

   state_t     state_q, state_d;
   logic       start_q;
   logic       start_rise;
   logic       stop_q, stop_d;
   logic       serve_q, serve_d;
   logic       game_over_q, game_over_d;
   logic [2:0] score1_q, score1_d;
   logic [2:0] score2_q, score2_d;
   logic [3:0] min_q, min_d;
   logic [3:0] sec1_q, sec1_d;
   logic [3:0] sec2_q, sec2_d;
   logic [3:0] serve_cnt_q, serve_cnt_d;

   // start_q resets high so a button held through reset release is not an edge
   assign start_rise = start & ~start_q;

   always_comb begin
      state_d     = state_q;
      serve_d     = 1'b0;
      score1_d    = score1_q;
      score2_d    = score2_q;
      min_d       = min_q;
      sec1_d      = sec1_q;
      sec2_d      = sec2_q;
      serve_cnt_d = serve_cnt_q;

      case (state_q)
         IDLE, OVER: begin
            if (start_rise) begin
               state_d     = SERVE;
               score1_d    = 3'd0;
               score2_d    = 3'd0;
               min_d       = GAME_MIN_L;
               sec1_d      = 4'd0;
               sec2_d      = 4'd0;
               serve_cnt_d = SERVE_SEC_L;
            end
         end
         SERVE: begin
            if (tick_1hz) begin
               serve_cnt_d = serve_cnt_q - 4'd1;
               if (serve_cnt_q == 4'd1) begin
                  state_d = PLAY;
                  serve_d = 1'b1;
               end
            end
         end
         PLAY: begin
            if (tick_1hz) begin
               if (sec2_q != 4'd0) begin
                  sec2_d = sec2_q - 4'd1;
               end else if (sec1_q != 4'd0) begin
                  sec1_d = sec1_q - 4'd1;
                  sec2_d = 4'd9;
               end else begin
                  min_d  = min_q - 4'd1;
                  sec1_d = 4'd5;
                  sec2_d = 4'd9;
               end
            end
            // a simultaneous double miss scores nothing and replays the point
            if (miss1 && !miss2) score2_d = score2_q + 3'd1;
            if (miss2 && !miss1) score1_d = score1_q + 3'd1;
            if (score1_d == WIN_SCORE_L || score2_d == WIN_SCORE_L ||
                {min_d, sec1_d, sec2_d} == 12'd0) begin
               state_d = OVER;
            end else if (miss1 || miss2) begin
               state_d     = SERVE;
               serve_cnt_d = SERVE_SEC_L;
            end
         end
         default: state_d = IDLE;
      endcase

      stop_d      = (state_d != PLAY);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         start_q     <= 1'b1;
         stop_q      <= 1'b1;
         serve_q     <= 1'b0;
         game_over_q <= 1'b0;
         score1_q    <= 3'd0;
         score2_q    <= 3'd0;
         min_q       <= GAME_MIN_L;
         sec1_q      <= 4'd0;
         sec2_q      <= 4'd0;
         serve_cnt_q <= SERVE_SEC_L;
      end else begin
         state_q     <= state_d;
         start_q     <= start;
         stop_q      <= stop_d;
         serve_q     <= serve_d;
         game_over_q <= game_over_d;
         score1_q    <= score1_d;
         score2_q    <= score2_d;
         min_q       <= min_d;
         sec1_q      <= sec1_d;
         sec2_q      <= sec2_d;
         serve_cnt_q <= serve_cnt_d;
      end
   end

   always_comb begin
      winner = 2'b00;
      if (game_over_q) begin
         if (score1_q > score2_q)      winner = 2'b01;
         else if (score2_q > score1_q) winner = 2'b10;
         else                          winner = 2'b11;
      end
   end

   assign stop      = stop_q;
   assign serve     = serve_q;
   assign game_over = game_over_q;
   assign score1    = score1_q;
   assign score2    = score2_q;
   assign min       = min_q;
   assign sec1      = sec1_q;
   assign sec2      = sec2_q;
   assign state     = state_q;

endmodule
